// File: rtl/tanh_pkg.sv
// Shared types and constants for the tanh scheduler: Q5.26 constants, FSM states
// and the parameter range check used at elaboration.
package tanh_pkg;

  localparam logic [31:0] Q_ONE = 32'h0400_0000;
  localparam logic [31:0] Q_SAT = 32'h0533_3333;

  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    ABORT = 3'd4
  } state_t;

  // Watchdog is 6 bits wide, so TIMEOUT must fit in it.
  function automatic logic params_ok(input int n_req, input int timeout);
    return (n_req >= N_REQ_MIN) && (n_req <= N_REQ_MAX) &&
           (timeout >= 16) && (timeout <= 63);
  endfunction

endpackage

// File: rtl/tanh_sched_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gnt_idx,
  output logic [PW-1:0] next_ptr,
  output logic          any
);

  logic [PW-1:0] idx_s;

  // Scan from the pointer and keep the first hit.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    next_ptr = '0;
    any      = 1'b0;
    idx_s    = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = PW'((int'(ptr) + k) % N);
      if (!any && req[idx_s]) begin
        any          = 1'b1;
        grant[idx_s] = 1'b1;
        gnt_idx      = idx_s;
        next_ptr     = PW'((int'(idx_s) + 1) % N);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/tanh_sched.sv
// Round-robin scheduler sharing one tanhz unit between N_REQ requesters, with
// a watchdog that aborts the unit through locked when it stalls.
module tanh_sched
  import tanh_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*32-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   resp_valid,
  output logic [31:0]        resp_data,
  output logic               resp_err,
  output logic [31:0]        oz,
  output logic               wa,
  output logic               locked,
  output logic               require,
  output logic               comp,
  input  logic [31:0]        tanh,
  input  logic               en
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [5:0] TO_V = 6'(TIMEOUT);

  if (!params_ok(N_REQ, TIMEOUT)) begin : g_param_err
    $error("tanh_sched: N_REQ must be 2..8 and TIMEOUT 16..63");
  end

  state_t            state_r;
  logic [IW-1:0]     ptr_r;
  logic [IW-1:0]     id_r;
  logic [5:0]        wd_r;
  logic              en_q_r;
  logic [N_REQ-1:0]  grant_s;
  logic [IW-1:0]     gidx_s;
  logic [IW-1:0]     nptr_s;
  logic              any_s;
  logic [31:0]       slice_s;
  logic [N_REQ-1:0]  id_oh_s;
  logic [5:0]        wd_inc_s;

  rr_arbiter #(.N(N_REQ), .PW(IW)) u_arb (
    .req      (req_valid),
    .ptr      (ptr_r),
    .grant    (grant_s),
    .gnt_idx  (gidx_s),
    .next_ptr (nptr_s),
    .any      (any_s)
  );

  // Operand of the granted requester (grant is one-hot, so OR-merge is exact).
  always_comb begin
    slice_s = 32'd0;
    for (int i = 0; i < N_REQ; i++) begin
      slice_s = slice_s | ({32{grant_s[i]}} & req_data[i*32 +: 32]);
    end
  end

  assign id_oh_s  = {{(N_REQ-1){1'b0}}, 1'b1} << id_r;
  assign wd_inc_s = (wd_r == 6'h3F) ? wd_r : wd_r + 6'd1;

  // Transaction FSM; every output is registered and pulses default low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= '0;
      id_r       <= '0;
      wd_r       <= 6'd0;
      en_q_r     <= 1'b0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_data  <= 32'd0;
      resp_err   <= 1'b0;
      oz         <= 32'd0;
      wa         <= 1'b1;
      locked     <= 1'b1;
      require    <= 1'b0;
      comp       <= 1'b0;
    end else begin
      req_ready  <= '0;
      resp_valid <= '0;
      resp_err   <= 1'b0;
      comp       <= 1'b0;
      case (state_r)
        IDLE: begin
          locked  <= 1'b0;
          wa      <= 1'b1;
          require <= 1'b0;
          if (any_s) begin
            req_ready <= grant_s;
            oz        <= slice_s;
            id_r      <= gidx_s;
            ptr_r     <= nptr_s;
            wd_r      <= 6'd0;
            en_q_r    <= 1'b0;
            state_r   <= ISSUE;
          end
        end
        ISSUE: begin
          wa      <= 1'b0;
          require <= 1'b1;
          wd_r    <= wd_inc_s;
          state_r <= WAIT;
        end
        WAIT: begin
          wa      <= 1'b1;
          require <= 1'b1;
          en_q_r  <= en;
          wd_r    <= wd_inc_s;
          // en may lead the settled sign by a cycle: require it on two consecutive cycles.
          if (en && en_q_r) begin
            resp_data <= tanh;
            state_r   <= RESP;
          end else if (wd_r == TO_V) begin
            state_r <= ABORT;
          end
        end
        RESP: begin
          resp_valid <= id_oh_s;
          comp       <= 1'b1;
          require    <= 1'b0;
          state_r    <= IDLE;
        end
        ABORT: begin
          locked     <= 1'b1;
          resp_valid <= id_oh_s;
          resp_err   <= 1'b1;
          resp_data  <= 32'd0;
          require    <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          locked  <= 1'b1;
          wa      <= 1'b1;
          require <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
